// File: rtl/tagsort_pkg.sv
// rtl/tagsort_pkg.sv - shared FSM encoding and constants for the tag free-list memory
package tagsort_pkg;

  // Free-list manager states
  typedef enum logic [1:0] {
    ST_INIT       = 2'd0,
    ST_IDLE       = 2'd1,
    ST_ALLOC_WAIT = 2'd2
  } state_t;

  // Address 0 terminates the list and is never handed out
  localparam int NULL_PTR = 0;

  // Read-during-write behaviour of the data RAM
  localparam int RD_OLD = 0;
  localparam int RD_NEW = 1;

endpackage

// File: rtl/tagsort_linked_mem_if.sv
// rtl/tagsort_linked_mem_if.sv - tag allocate/release handshake bundle
interface tagsort_linked_mem_if #(parameter int N = 13);
  logic         alloc_req;
  logic         alloc_ready;
  logic [N-1:0] alloc_addr;
  logic         free_valid;
  logic [N-1:0] free_addr;
  logic         free_ready;

  modport master (
    output alloc_req, free_valid, free_addr,
    input  alloc_ready, alloc_addr, free_ready
  );

  modport slave (
    input  alloc_req, free_valid, free_addr,
    output alloc_ready, alloc_addr, free_ready
  );
endinterface

// File: rtl/tagsort_link_ram.sv
// rtl/tagsort_link_ram.sv - next-pointer storage, one write port, one registered read port
module tagsort_link_ram #(
  parameter int N = 13
) (
  input  logic         clk,
  input  logic         we,
  input  logic [N-1:0] waddr,
  input  logic [N-1:0] wdata,
  input  logic [N-1:0] raddr,
  output logic [N-1:0] rdata
);

  logic [N-1:0] mem [2**N];

  // Plain synchronous RAM: no reset so it maps onto block memory
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tagsort_linked_mem.sv
// rtl/tagsort_linked_mem.sv - data RAM with a linked free list of tags
module tagsort_linked_mem
  import tagsort_pkg::*;
#(
  parameter int N       = 13,
  parameter int B       = 64,
  parameter int RD_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [N-1:0]         w_addr,
  input  logic [B-1:0]         w_data,
  input  logic [N-1:0]         r_addr1,
  output logic [B-1:0]         r_data1,
  input  logic [N-1:0]         r_addr2,
  output logic [B-1:0]         r_data2,
  tagsort_linked_mem_if.slave  tag,
  output logic [N:0]           free_cnt,
  output logic                 init_done,
  output logic                 err_free_null
);

  localparam logic [N-1:0] LAST_IDX = {N{1'b1}};
  localparam logic [N:0]   FULL_CNT = {1'b0, {N{1'b1}}};
  localparam logic [N-1:0] NULL_A   = N'(NULL_PTR);

  state_t       state, state_next;
  logic [N-1:0] init_idx;
  logic [N-1:0] head;
  logic         alloc_ok, alloc_go, free_go, free_null, swap;
  logic         link_we;
  logic [N-1:0] link_waddr, link_wdata, link_raddr, link_rdata;
  logic [B-1:0] mem [2**N];

  assign alloc_ok        = (state == ST_IDLE) && (free_cnt != '0);
  assign alloc_go        = tag.alloc_req && alloc_ok;
  assign free_go         = tag.free_valid && (state == ST_IDLE);
  assign free_null       = (tag.free_addr == NULL_A);
  // A simultaneous alloc and valid free just hands the freed tag straight back
  assign swap            = alloc_go && free_go && !free_null;
  assign tag.alloc_ready = alloc_ok;
  assign tag.free_ready  = (state == ST_IDLE);
  assign tag.alloc_addr  = swap ? tag.free_addr : head;

  tagsort_link_ram #(.N(N)) u_link (
    .clk   (clk),
    .we    (link_we),
    .waddr (link_waddr),
    .wdata (link_wdata),
    .raddr (link_raddr),
    .rdata (link_rdata)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  // Next state and link-RAM access
  always_comb begin
    state_next = state;
    link_we    = 1'b0;
    link_waddr = init_idx;
    link_wdata = NULL_A;
    link_raddr = head;
    case (state)
      ST_INIT: begin
        link_we    = !rst;
        link_waddr = init_idx;
        link_wdata = (init_idx == LAST_IDX) ? NULL_A : init_idx + 1'b1;
        if (init_idx == LAST_IDX) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (alloc_go && !swap) begin
          state_next = ST_ALLOC_WAIT;
        end else if (free_go && !free_null && !alloc_go) begin
          link_we    = 1'b1;
          link_waddr = tag.free_addr;
          link_wdata = head;
        end
      end
      ST_ALLOC_WAIT: state_next = ST_IDLE;
      default:       state_next = ST_INIT;
    endcase
  end

  // Free-list head, count, init progress and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      init_idx      <= 1;
      head          <= NULL_A;
      free_cnt      <= '0;
      init_done     <= 1'b0;
      err_free_null <= 1'b0;
    end else begin
      err_free_null <= free_go && free_null;
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == LAST_IDX) begin
            head      <= 1;
            free_cnt  <= FULL_CNT;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (free_go && !free_null && !alloc_go) begin
            head     <= tag.free_addr;
            free_cnt <= free_cnt + 1'b1;
          end
        end
        ST_ALLOC_WAIT: begin
          head     <= link_rdata;
          free_cnt <= free_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end

  // Registered read ports with optional write-first bypass
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data1 <= '0;
      r_data2 <= '0;
    end else begin
      r_data1 <= (RD_MODE == RD_NEW && wr_en && w_addr == r_addr1) ? w_data : mem[r_addr1];
      r_data2 <= (RD_MODE == RD_NEW && wr_en && w_addr == r_addr2) ? w_data : mem[r_addr2];
    end
  end

endmodule
